// File: rtl/dpram_pkg.sv
// Shared types and helpers for the dual-port RAM bank and its clear sequencer.
package dpram_pkg;

  typedef enum logic {
    CLR_CLEAR = 1'b0,
    CLR_READY = 1'b1
  } clr_state_e;

  // Ceiling log2, usable in parameter expressions.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/dpram_clear_seq.sv
// Clear sequencer: walks every word once after reset or on request, then
// holds READY until the next clear request.
module dpram_clear_seq
  import dpram_pkg::*;
#(
  parameter int DEPTH = 16384,
  parameter int WA    = 14
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_clear,
  output logic          o_ready,
  output logic          clr_we,
  output logic [WA-1:0] clr_addr
);

  clr_state_e    state_q, state_d;
  logic [WA-1:0] cnt_q, cnt_d;

  // Next-state and counter logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      CLR_CLEAR: begin
        if (cnt_q == WA'(DEPTH - 1)) begin
          state_d = CLR_READY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + WA'(1);
        end
      end
      CLR_READY: begin
        if (i_clear) begin
          state_d = CLR_CLEAR;
          cnt_d   = '0;
        end else begin
          cnt_d = '0;
        end
      end
      default: begin
        state_d = CLR_CLEAR;
        cnt_d   = '0;
      end
    endcase
  end

  // State and counter registers.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= CLR_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_ready  = (state_q == CLR_READY);
  assign clr_we   = (state_q == CLR_CLEAR);
  assign clr_addr = cnt_q;

endmodule

// File: rtl/dpram_bank.sv
// True dual-port RAM bank with byte enables, read-first semantics, port-A
// priority on same-byte writes, optional output register and hardware clear.
module dpram_bank
  import dpram_pkg::*;
#(
  parameter  int              DATA_W    = 32,
  parameter  int              DEPTH     = 16384,
  parameter  int              OUT_REG   = 0,
  parameter  logic [DATA_W-1:0] CLEAR_VAL = '0,
  localparam int              NB        = DATA_W / 8,
  localparam int              AW        = clog2(DEPTH * NB)
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_clear,
  output logic              o_ready,
  input  logic [AW-1:0]     address_a,
  input  logic [DATA_W-1:0] data_a,
  input  logic [NB-1:0]     wren_a,
  input  logic              rden_a,
  output logic [DATA_W-1:0] q_a,
  output logic              rvalid_a,
  input  logic [AW-1:0]     address_b,
  input  logic [DATA_W-1:0] data_b,
  input  logic [NB-1:0]     wren_b,
  input  logic              rden_b,
  output logic [DATA_W-1:0] q_b,
  output logic              rvalid_b,
  output logic              o_collision
);

  localparam int LB = clog2(NB);
  localparam int WA = AW - LB;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              clr_we;
  logic [WA-1:0]     clr_addr;
  logic [WA-1:0]     wa_a_s, wa_b_s;
  logic [NB-1:0]     we_a_s, we_b_s;
  logic              rd_a_s, rd_b_s;
  logic [DATA_W-1:0] rdata_a_s, rdata_b_s;

  logic [DATA_W-1:0] p_a_q, p_a_d, p_b_q, p_b_d;
  logic              pv_a_q, pv_a_d, pv_b_q, pv_b_d;
  logic [DATA_W-1:0] q_a_q, q_a_d, q_b_q, q_b_d;
  logic              rv_a_q, rv_a_d, rv_b_q, rv_b_d;
  logic              coll_q, coll_d;

  dpram_clear_seq #(
    .DEPTH (DEPTH),
    .WA    (WA)
  ) u_clear_seq (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_clear  (i_clear),
    .o_ready  (o_ready),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  assign wa_a_s = address_a[AW-1:LB];
  assign wa_b_s = address_b[AW-1:LB];

  generate
    if (LB > 0) begin : g_unused_lsb
      logic unused_lsb_s;
      assign unused_lsb_s = ^{address_a[LB-1:0], address_b[LB-1:0]};
    end
  endgenerate

  // Access qualification: nothing reaches the array while clearing.
  always_comb begin
    we_a_s    = o_ready ? wren_a : '0;
    we_b_s    = o_ready ? wren_b : '0;
    rd_a_s    = o_ready & rden_a;
    rd_b_s    = o_ready & rden_b;
    rdata_a_s = mem[wa_a_s];
    rdata_b_s = mem[wa_b_s];
    coll_d    = (wa_a_s == wa_b_s) && ((we_a_s & we_b_s) != '0);
  end

  // Single write process: B lanes first, then A lanes, so A wins any shared byte.
  always_ff @(posedge i_clk) begin
    if (clr_we) begin
      mem[clr_addr] <= CLEAR_VAL;
    end else begin
      for (int b = 0; b < NB; b++) begin
        if (we_b_s[b]) mem[wa_b_s][b*8 +: 8] <= data_b[b*8 +: 8];
      end
      for (int b = 0; b < NB; b++) begin
        if (we_a_s[b]) mem[wa_a_s][b*8 +: 8] <= data_a[b*8 +: 8];
      end
    end
  end

  // Read pipeline: q only moves when an accepted read reaches the output stage.
  always_comb begin
    p_a_d  = rd_a_s ? rdata_a_s : p_a_q;
    p_b_d  = rd_b_s ? rdata_b_s : p_b_q;
    pv_a_d = rd_a_s;
    pv_b_d = rd_b_s;
    if (OUT_REG != 0) begin
      q_a_d  = pv_a_q ? p_a_q : q_a_q;
      q_b_d  = pv_b_q ? p_b_q : q_b_q;
      rv_a_d = pv_a_q;
      rv_b_d = pv_b_q;
    end else begin
      q_a_d  = rd_a_s ? rdata_a_s : q_a_q;
      q_b_d  = rd_b_s ? rdata_b_s : q_b_q;
      rv_a_d = rd_a_s;
      rv_b_d = rd_b_s;
    end
  end

  // Output and pipeline registers.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      p_a_q  <= '0;
      p_b_q  <= '0;
      pv_a_q <= 1'b0;
      pv_b_q <= 1'b0;
      q_a_q  <= '0;
      q_b_q  <= '0;
      rv_a_q <= 1'b0;
      rv_b_q <= 1'b0;
      coll_q <= 1'b0;
    end else begin
      p_a_q  <= p_a_d;
      p_b_q  <= p_b_d;
      pv_a_q <= pv_a_d;
      pv_b_q <= pv_b_d;
      q_a_q  <= q_a_d;
      q_b_q  <= q_b_d;
      rv_a_q <= rv_a_d;
      rv_b_q <= rv_b_d;
      coll_q <= coll_d;
    end
  end

  assign q_a         = q_a_q;
  assign q_b         = q_b_q;
  assign rvalid_a    = rv_a_q;
  assign rvalid_b    = rv_b_q;
  assign o_collision = coll_q;

endmodule

// File: tb/tb_dpram_bank.sv
// Randomised scoreboard bench for dpram_bank: one instance without and one
// with the output register, driven from the same stimulus.
module tb_dpram_bank;

  localparam int DEPTH = 64;
  localparam int DW    = 32;
  localparam int AW    = 8;

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  logic          clk, rst, i_clear;
  logic [AW-1:0] address_a, address_b;
  logic [31:0]   data_a, data_b;
  logic [3:0]    wren_a, wren_b;
  logic          rden_a, rden_b;

  logic [31:0] q_a0, q_b0, q_a1, q_b1;
  logic        rv_a0, rv_b0, rv_a1, rv_b1;
  logic        rdy0, rdy1, coll0, coll1;

  dpram_bank #(.DATA_W(DW), .DEPTH(DEPTH), .OUT_REG(0)) u_dut0 (
    .i_clk(clk), .i_reset(rst), .i_clear(i_clear), .o_ready(rdy0),
    .address_a(address_a), .data_a(data_a), .wren_a(wren_a), .rden_a(rden_a),
    .q_a(q_a0), .rvalid_a(rv_a0),
    .address_b(address_b), .data_b(data_b), .wren_b(wren_b), .rden_b(rden_b),
    .q_b(q_b0), .rvalid_b(rv_b0), .o_collision(coll0)
  );

  dpram_bank #(.DATA_W(DW), .DEPTH(DEPTH), .OUT_REG(1)) u_dut1 (
    .i_clk(clk), .i_reset(rst), .i_clear(i_clear), .o_ready(rdy1),
    .address_a(address_a), .data_a(data_a), .wren_a(wren_a), .rden_a(rden_a),
    .q_a(q_a1), .rvalid_a(rv_a1),
    .address_b(address_b), .data_b(data_b), .wren_b(wren_b), .rden_b(rden_b),
    .q_b(q_b1), .rvalid_b(rv_b1), .o_collision(coll1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  logic [31:0] mem_m [DEPTH];
  bit          rdy_m, coll_m;
  int          clr_left;
  int          edge_n;
  exp_t        exp_q [4][$];
  logic [31:0] last_q [4];
  bit          run;

  int n_vec, n_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (edge %0d)", name, act, req, edge_n);
    end
  endtask

  task automatic chk_port(input int p, input logic rv, input logic [31:0] q);
    exp_t e;
    string nm;
    nm = (p == 0) ? "d0.a" : (p == 1) ? "d0.b" : (p == 2) ? "d1.a" : "d1.b";
    if (rv) begin
      if (exp_q[p].size() == 0) begin
        chk({nm, " spurious_rvalid"}, 32'd1, 32'd0);
      end else begin
        e = exp_q[p].pop_front();
        chk({nm, " latency"}, edge_n, e.due);
        chk({nm, " rdata"}, q, e.data);
        last_q[p] = e.data;
      end
    end else begin
      if (exp_q[p].size() > 0 && exp_q[p][0].due <= edge_n) begin
        e = exp_q[p].pop_front();
        chk({nm, " missing_rvalid"}, 32'd0, 32'd1);
      end
      chk({nm, " q_hold"}, q, last_q[p]);
    end
  endtask

  // Monitor: compare every output on the falling edge
  always @(negedge clk) begin
    if (run && !rst) begin
      chk_port(0, rv_a0, q_a0);
      chk_port(1, rv_b0, q_b0);
      chk_port(2, rv_a1, q_a1);
      chk_port(3, rv_b1, q_b1);
      chk("d0 ready", {31'd0, rdy0}, {31'd0, rdy_m});
      chk("d1 ready", {31'd0, rdy1}, {31'd0, rdy_m});
      chk("d0 collision", {31'd0, coll0}, {31'd0, coll_m});
      chk("d1 collision", {31'd0, coll1}, {31'd0, coll_m});
    end
  end

  task automatic idle_inputs();
    i_clear = 1'b0;
    address_a = '0; address_b = '0;
    data_a = '0; data_b = '0;
    wren_a = '0; wren_b = '0;
    rden_a = 1'b0; rden_b = 1'b0;
  endtask

  // Apply the current inputs for one clock and advance the model.
  task automatic step();
    bit   rdy_n, coll_n;
    int   wa, wb;
    exp_t e;
    rdy_n  = rdy_m;
    coll_n = 1'b0;
    wa = int'(address_a[AW-1:2]);
    wb = int'(address_b[AW-1:2]);
    if (rdy_m) begin
      if (rden_a) begin
        e.data = mem_m[wa];
        e.due = edge_n + 1; exp_q[0].push_back(e);
        e.due = edge_n + 2; exp_q[2].push_back(e);
      end
      if (rden_b) begin
        e.data = mem_m[wb];
        e.due = edge_n + 1; exp_q[1].push_back(e);
        e.due = edge_n + 2; exp_q[3].push_back(e);
      end
      coll_n = (wa == wb) && ((wren_a & wren_b) != 4'd0);
      for (int b = 0; b < 4; b++) begin
        if (wren_a[b]) mem_m[wa][b*8 +: 8] = data_a[b*8 +: 8];
        else if (wren_b[b]) mem_m[wb][b*8 +: 8] = data_b[b*8 +: 8];
      end
      if (wren_a == 4'd0 || wa != wb) begin
        for (int b = 0; b < 4; b++)
          if (wren_b[b] && !(wa == wb && wren_a[b])) mem_m[wb][b*8 +: 8] = data_b[b*8 +: 8];
      end
      if (i_clear) begin
        rdy_n    = 1'b0;
        clr_left = DEPTH;
      end
    end else begin
      mem_m[DEPTH - clr_left] = 32'd0;
      clr_left--;
      if (clr_left == 0) rdy_n = 1'b1;
    end
    @(posedge clk);
    edge_n++;
    rdy_m  = rdy_n;
    coll_m = coll_n;
    #1;
  endtask

  task automatic do_reset(input int hold);
    rst = 1'b1;
    #1;
    chk("rst q_a0", q_a0, 32'd0);
    chk("rst q_b1", q_b1, 32'd0);
    chk("rst rvalid", {28'd0, rv_a0, rv_b0, rv_a1, rv_b1}, 32'd0);
    chk("rst ready", {30'd0, rdy0, rdy1}, 32'd0);
    chk("rst collision", {30'd0, coll0, coll1}, 32'd0);
    for (int p = 0; p < 4; p++) begin
      exp_q[p].delete();
      last_q[p] = 32'd0;
    end
    rdy_m    = 1'b0;
    coll_m   = 1'b0;
    clr_left = DEPTH;
    repeat (hold) @(posedge clk);
    @(posedge clk);
    edge_n++;
    #1;
    rst = 1'b0;
  endtask

  task automatic rand_inputs(input bit allow_clear);
    address_a = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 31)) : AW'($urandom);
    address_b = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 31)) : AW'($urandom);
    data_a = $urandom;
    data_b = $urandom;
    wren_a = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'd0;
    wren_b = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'd0;
    rden_a = 1'($urandom);
    rden_b = 1'($urandom);
    i_clear = allow_clear && ($urandom_range(0, 79) == 0);
  endtask

  initial begin
    n_vec = 0; n_err = 0; edge_n = 0; run = 1'b0;
    rst = 1'b0;
    idle_inputs();
    for (int i = 0; i < DEPTH; i++) mem_m[i] = 32'd0;
    #2;
    run = 1'b1;

    // 1: clear after reset, backdoor-dirtied word must be zero
    do_reset(2);
    u_dut0.mem[5] = 32'hDEADBEEF;
    u_dut1.mem[5] = 32'hDEADBEEF;
    repeat (DEPTH - 1) step();
    chk("ready_before_64", {31'd0, rdy0}, 32'd0);
    step();
    chk("ready_at_64", {31'd0, rdy0}, 32'd1);
    address_a = 8'h14; rden_a = 1'b1;
    step();
    idle_inputs();
    chk("clear_word5", q_a0, 32'h0000_0000);
    chk("clear_word5_rv", {31'd0, rv_a0}, 32'd1);

    // 2: byte-enable write then read
    address_a = 8'h08; data_a = 32'h11223344; wren_a = 4'b0101;
    step();
    idle_inputs();
    address_a = 8'h08; rden_a = 1'b1;
    step();
    idle_inputs();
    chk("byte_we d0", q_a0, 32'h00220044);
    chk("byte_we d1 early", {31'd0, rv_a1}, 32'd0);
    step();
    chk("byte_we d1", q_a1, 32'h00220044);

    // 3: same-word collision and disjoint enables
    address_a = 8'h20; data_a = 32'hAAAAAAAA; wren_a = 4'b0011;
    address_b = 8'h20; data_b = 32'hBBBBBBBB; wren_b = 4'b0110;
    step();
    idle_inputs();
    chk("coll_pulse", {31'd0, coll0}, 32'd1);
    address_b = 8'h20; rden_b = 1'b1;
    step();
    idle_inputs();
    chk("coll_drop", {31'd0, coll0}, 32'd0);
    chk("coll_merge", q_b0, 32'h00BBAAAA);
    address_a = 8'h20; data_a = 32'h01020304; wren_a = 4'b0001;
    address_b = 8'h21; data_b = 32'h05060708; wren_b = 4'b0010;
    step();
    idle_inputs();
    chk("coll_disjoint", {31'd0, coll0}, 32'd0);

    // 4: read-first across ports
    address_a = 8'h0C; data_a = 32'h1; wren_a = 4'hF;
    step();
    address_a = 8'h0C; data_a = 32'h2; wren_a = 4'hF;
    address_b = 8'h0C; rden_b = 1'b1;
    step();
    idle_inputs();
    chk("read_first_old", q_b0, 32'h1);
    address_b = 8'h0C; rden_b = 1'b1;
    step();
    idle_inputs();
    chk("read_first_new", q_b0, 32'h2);

    // 5: clear request in the middle of traffic
    address_a = 8'h1C; data_a = 32'h55; wren_a = 4'hF;
    step();
    idle_inputs();
    i_clear = 1'b1;
    step();
    repeat (DEPTH) begin
      rand_inputs(1'b0);
      step();
    end
    idle_inputs();
    address_a = 8'h1C; rden_a = 1'b1;
    step();
    idle_inputs();
    chk("clear_word7", q_a0, 32'h0);

    // 6: reset in the middle of a clear
    do_reset(1);
    repeat (30) step();
    do_reset(2);
    chk("midclr_ready", {31'd0, rdy0}, 32'd0);
    repeat (DEPTH - 1) step();
    chk("midclr_before_64", {31'd0, rdy0}, 32'd0);
    step();
    chk("midclr_at_64", {31'd0, rdy0}, 32'd1);

    // Random traffic with occasional clear requests
    repeat (600) begin
      rand_inputs(1'b1);
      step();
    end
    idle_inputs();
    repeat (4) step();
    for (int p = 0; p < 4; p++)
      chk("drain", exp_q[p].size(), 32'd0);

    run = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dpram_bank.md
Name: dpram_bank

Overview:
Parametrised true dual-port synchronous RAM bank; next-generation data memory for the core and debug/DMA side.
Adds to the fixed 64 KiB DMEM: generic width/depth, optional output register, read-valid tracking, deterministic same-word write collision resolution, and a hardware clear sequencer that zeroes the array after reset or on request.
Port A serves the LSU; port B serves the peripheral/debug master.

Parameters:
DATA_W, 32, word width in bits; multiple of 8.
DEPTH, 16384, number of words; power of two.
OUT_REG, 0, 1 adds an output pipeline register (read latency 2 instead of 1).
CLEAR_VAL, 0, word value written by the clear sequencer.
Derived: NB = DATA_W/8; AW = log2(DEPTH*NB), byte-address width.

Ports:
i_clk  in  1  clock, all state on rising edge.
i_reset  in  1  reset; asynchronous, active-high.
i_clear  in  1  single-cycle request to re-run clear sequence.
o_ready  out  1  high when the array accepts port accesses.
address_a  in  AW  port A byte address.
data_a  in  DATA_W  port A write data.
wren_a  in  NB  port A byte write enables.
rden_a  in  1  port A read request.
q_a  out  DATA_W  port A read data.
rvalid_a  out  1  q_a holds data for an accepted read.
address_b, data_b, wren_b, rden_b, q_b, rvalid_b: port B, identical to port A.
o_collision  out  1  pulse: both ports wrote overlapping bytes of one word.

Behaviour:
- Word address = byte address >> log2(NB); low log2(NB) bits ignored (no misalignment trap).
- Reset: q_a=q_b=0, rvalid_a=rvalid_b=0, o_collision=0, o_ready=0, FSM=CLEAR, clear counter=0.
- FSM states: CLEAR, READY.
  - CLEAR: writes CLEAR_VAL to word[cnt] each cycle, cnt++; after word DEPTH-1 is written, go to READY next cycle. Exactly DEPTH cycles in CLEAR.
  - READY: o_ready=1; i_clear=1 -> CLEAR with cnt=0 (o_ready drops the next cycle).
  - i_reset mid-clear: counter restarts at 0; previous partial clear is irrelevant.
- While o_ready=0: port writes are dropped, reads are not accepted (rvalid stays 0), and q_x holds its value.
- Accept: a port access is accepted when o_ready=1 in that cycle. A read is accepted when rden_x=1. Writes do not require rden_x.
- Read latency: accepted in cycle N -> q_x/rvalid_x valid at edge N+1 (OUT_REG=0) or N+2 (OUT_REG=1). rvalid_x is high for one cycle per accepted read. Back-to-back reads are supported at full throughput.
- q_x is updated only on an accepted read and holds its value otherwise.
- Read-during-write: read-first on both ports, same or cross port. The read returns the pre-edge word; the new data is visible to reads in the next cycle.
- Same-word writes from both ports in one cycle:
  - Port A wins each byte enabled on both ports.
  - Bytes enabled on only one port take that port's data.
  - o_collision=1 the following cycle iff (wren_a & wren_b) != 0; otherwise 0.
- All writes go through a single write process, so the result is deterministic in simulation and synthesis.
- No X on outputs after reset; the array content is defined only after CLEAR completes.

Decomposition:
- dpram_pkg holds:
  - typedef enum clr_state_e {CLR_CLEAR, CLR_READY};
  - function clog2 helper used for AW.
- One natural sub-module, dpram_clear_seq: clear FSM plus counter. Outputs o_ready, clr_we, clr_addr.
- The array, port logic and collision merge stay in dpram_bank.

Test Plan:
- Test parameters: DEPTH=64, DATA_W=32, OUT_REG=0.
1. Clear after reset: pulse i_reset, preload word 5 via backdoor = 0xDEADBEEF, no requests -> o_ready rises exactly 64 cycles after reset release; read addr 0x14 -> q_a=0x00000000, rvalid_a one cycle later.
2. Byte-enable write then read: write addr 0x08, data 0x11223344, wren=4'b0101; read -> 0x00220044. Repeat with OUT_REG=1 -> data appears 2 cycles after the read is accepted.
3. Collision: same cycle, A writes 0x20 data 0xAAAAAAAA wren=4'b0011; B writes 0x20 data 0xBBBBBBBB wren=4'b0110 -> word=0x00BBAAAA, o_collision=1 for one cycle. Disjoint enables -> o_collision=0.
4. Read-first: word 3=0x1; in one cycle A writes 0x2 to addr 0x0C and B reads 0x0C -> q_b=0x1; B reads again next cycle -> 0x2.
5. Clear mid-traffic: in READY, write 0x55 to word 7, pulse i_clear, issue writes and reads during CLEAR -> rvalid stays 0, writes dropped; after 64 cycles word 7 reads 0x0.
6. Reset mid-clear: assert i_reset at clear cycle 30 -> outputs return to reset values immediately; o_ready rises 64 cycles after release.
